// File: rtl/fir_coeff_ctrl.sv
// Double-buffered FIR coefficient controller: requesters write a shadow bank, and a
// commit swaps it into the active bank. out_valid stays low until the filter pipeline has refilled.
module fir_coeff_ctrl #(
  parameter int NTAPS        = 21,
  parameter int CW           = 16,
  parameter int FLUSH_CYCLES = 23,
  parameter logic [NTAPS*CW-1:0] COEF_INIT = {
    16'hFFF4, 16'hFFE7, 16'h0000, 16'h0050, 16'h00B4, 16'h00D2, 16'h0000,
    16'hFE0C, 16'hFC18, 16'h04B0, 16'h2000, 16'h04B0, 16'hFC18, 16'hFE0C,
    16'h0000, 16'h00D2, 16'h00B4, 16'h0050, 16'h0000, 16'hFFE7, 16'hFFF4
  }
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [4:0]             cfg_addr,
  input  logic signed [CW-1:0]   cfg_data,
  input  logic                   cfg_commit,
  input  logic                   in_valid,
  output logic [NTAPS*CW-1:0]    coeffs,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   addr_err,
  output logic [7:0]             commit_cnt
);

  localparam int CNTW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {RUN, SWAP, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [NTAPS*CW-1:0]   shadow_q, shadow_d;
  logic [NTAPS*CW-1:0]   active_q, active_d;
  logic [CNTW-1:0]       flush_cnt_q, flush_cnt_d;
  logic                  pending_q, pending_d;
  logic                  addr_err_q, addr_err_d;
  logic [7:0]            commit_cnt_q, commit_cnt_d;
  logic                  wr_accept;
  logic                  addr_ok;

  assign wr_accept  = cfg_valid && (state_q == RUN);
  assign addr_ok    = ({27'd0, cfg_addr} < 32'(NTAPS));

  assign cfg_ready  = (state_q == RUN);
  assign out_valid  = (state_q == RUN);
  assign busy       = (state_q != RUN);
  assign coeffs     = active_q;
  assign addr_err   = addr_err_q;
  assign commit_cnt = commit_cnt_q;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    flush_cnt_d  = flush_cnt_q;
    pending_d    = pending_q;
    addr_err_d   = addr_err_q;
    commit_cnt_d = commit_cnt_q;

    case (state_q)
      RUN: begin
        if (wr_accept) begin
          if (addr_ok) begin
            for (int k = 0; k < NTAPS; k++) begin
              if (cfg_addr == 5'(k)) shadow_d[k*CW +: CW] = cfg_data;
            end
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (cfg_commit) begin
          state_d   = SWAP;
          pending_d = 1'b0;
        end
      end

      SWAP: begin
        active_d     = shadow_q;
        commit_cnt_d = commit_cnt_q + 8'd1;
        flush_cnt_d  = '0;
        state_d      = FLUSH;
        if (cfg_commit) pending_d = 1'b1;
      end

      FLUSH: begin
        if (cfg_commit) pending_d = 1'b1;
        if (in_valid) begin
          flush_cnt_d = flush_cnt_q + CNTW'(1);
          // A commit arriving on the exit cycle still counts as pending.
          if (flush_cnt_q == CNTW'(FLUSH_CYCLES - 1)) begin
            if (pending_q || cfg_commit) begin
              state_d   = SWAP;
              pending_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end
        end
      end

      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FLUSH;
      shadow_q     <= COEF_INIT;
      active_q     <= COEF_INIT;
      flush_cnt_q  <= '0;
      pending_q    <= 1'b0;
      addr_err_q   <= 1'b0;
      commit_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      flush_cnt_q  <= flush_cnt_d;
      pending_q    <= pending_d;
      addr_err_q   <= addr_err_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a table of single-cycle and flush records,
// followed by hand-written sequences for pending commits and mid-flush reset.
module tb_fir_coeff_ctrl;

  localparam int W = 336;
  localparam logic [W-1:0] INIT = {
    16'hFFF4, 16'hFFE7, 16'h0000, 16'h0050, 16'h00B4, 16'h00D2, 16'h0000,
    16'hFE0C, 16'hFC18, 16'h04B0, 16'h2000, 16'h04B0, 16'hFC18, 16'hFE0C,
    16'h0000, 16'h00D2, 16'h00B4, 16'h0050, 16'h0000, 16'hFFE7, 16'hFFF4
  };

  logic           clk;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [4:0]     cfg_addr;
  logic [15:0]    cfg_data;
  logic           cfg_commit;
  logic           in_valid;
  logic [W-1:0]   coeffs;
  logic           out_valid;
  logic           busy;
  logic           addr_err;
  logic [7:0]     commit_cnt;

  int vecCount  = 0;
  int missCount = 0;

  fir_coeff_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .in_valid   (in_valid),
    .coeffs     (coeffs),
    .out_valid  (out_valid),
    .busy       (busy),
    .addr_err   (addr_err),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [4:0]  addr;
    logic [15:0] data;
    logic        commit;
    logic        iv;
    int          flushLen;
    logic        expReady;
    logic        expBusy;
    logic        expOv;
    logic        expErr;
    logic [7:0]  expCnt;
    logic [15:0] expTap0;
    logic [15:0] expTap10;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic cv, input logic [4:0] addr, input logic [15:0] data,
                              input logic commit, input int flushLen, input logic r, input logic b,
                              input logic ov, input logic err, input logic [7:0] cnt,
                              input logic [15:0] t0, input logic [15:0] t10);
    vec_t v;
    v.cv = cv; v.addr = addr; v.data = data; v.commit = commit; v.iv = 1'b1;
    v.flushLen = flushLen; v.expReady = r; v.expBusy = b; v.expOv = ov; v.expErr = err;
    v.expCnt = cnt; v.expTap0 = t0; v.expTap10 = t10;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, land 1 time unit after the edge.
  task automatic applyStimulus(input logic cv, input logic [4:0] a, input logic [15:0] d,
                               input logic cm, input logic iv);
    cfg_valid  = cv;
    cfg_addr   = a;
    cfg_data   = d;
    cfg_commit = cm;
    in_valid   = iv;
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic runFlush(input logic toggle, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, toggle ? ((n % 2) == 1) : 1'b1);
      n++;
    end
  endtask

  task automatic doReset(input logic cv, input logic cm);
    reset = 1'b1;
    applyStimulus(cv, 5'd1, 16'h4321, cm, 1'b1);
    reset = 1'b0;
  endtask

  logic [W-1:0] expBank;
  int n;
  logic ovSeen;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0; in_valid = 1'b0;

    vecs[0]  = mk(1, 5'd10, 16'h1000, 0,  0, 1, 0, 1, 0, 8'd0, 16'hFFF4, 16'h2000);
    vecs[1]  = mk(0, 5'd0,  16'h0000, 1,  0, 0, 1, 0, 0, 8'd0, 16'hFFF4, 16'h2000);
    vecs[2]  = mk(1, 5'd3,  16'h5555, 0,  0, 0, 1, 0, 0, 8'd1, 16'hFFF4, 16'h1000);
    vecs[3]  = mk(0, 5'd0,  16'h0000, 0, 23, 1, 0, 1, 0, 8'd1, 16'hFFF4, 16'h1000);
    vecs[4]  = mk(1, 5'd0,  16'h7FFF, 1,  0, 0, 1, 0, 0, 8'd1, 16'hFFF4, 16'h1000);
    vecs[5]  = mk(0, 5'd0,  16'h0000, 0,  0, 0, 1, 0, 0, 8'd2, 16'h7FFF, 16'h1000);
    vecs[6]  = mk(0, 5'd0,  16'h0000, 0, 23, 1, 0, 1, 0, 8'd2, 16'h7FFF, 16'h1000);
    vecs[7]  = mk(1, 5'd25, 16'h1234, 0,  0, 1, 0, 1, 1, 8'd2, 16'h7FFF, 16'h1000);
    vecs[8]  = mk(0, 5'd0,  16'h0000, 1,  0, 0, 1, 0, 1, 8'd2, 16'h7FFF, 16'h1000);
    vecs[9]  = mk(0, 5'd0,  16'h0000, 0,  0, 0, 1, 0, 1, 8'd3, 16'h7FFF, 16'h1000);
    vecs[10] = mk(0, 5'd0,  16'h0000, 0, 23, 1, 0, 1, 1, 8'd3, 16'h7FFF, 16'h1000);

    // Reset has priority over a simultaneous write and commit.
    @(posedge clk); #1;
    doReset(1'b1, 1'b1);
    checkOutput("rst_busy", W'(busy), W'(1'b1));
    checkOutput("rst_ready", W'(cfg_ready), W'(1'b0));
    checkOutput("rst_out_valid", W'(out_valid), W'(1'b0));
    checkOutput("rst_addr_err", W'(addr_err), W'(1'b0));
    checkOutput("rst_commit_cnt", W'(commit_cnt), W'(8'd0));
    checkOutput("rst_coeffs", coeffs, INIT);

    runFlush(1'b0, n);
    checkOutput("init_flush_len", W'(n), W'(23));
    checkOutput("init_flush_coeffs", coeffs, INIT);
    checkOutput("init_flush_cnt", W'(commit_cnt), W'(8'd0));

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].flushLen != 0) begin
        runFlush(1'b0, n);
        checkOutput($sformatf("v%0d_flush_len", i), W'(n), W'(vecs[i].flushLen));
      end else begin
        applyStimulus(vecs[i].cv, vecs[i].addr, vecs[i].data, vecs[i].commit, vecs[i].iv);
      end
      checkOutput($sformatf("v%0d_ready", i), W'(cfg_ready), W'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_busy", i), W'(busy), W'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_out_valid", i), W'(out_valid), W'(vecs[i].expOv));
      checkOutput($sformatf("v%0d_addr_err", i), W'(addr_err), W'(vecs[i].expErr));
      checkOutput($sformatf("v%0d_commit_cnt", i), W'(commit_cnt), W'(vecs[i].expCnt));
      checkOutput($sformatf("v%0d_tap0", i), W'(coeffs[0 +: 16]), W'(vecs[i].expTap0));
      checkOutput($sformatf("v%0d_tap10", i), W'(coeffs[160 +: 16]), W'(vecs[i].expTap10));
    end

    expBank = INIT;
    expBank[0 +: 16]   = 16'h7FFF;
    expBank[160 +: 16] = 16'h1000;
    checkOutput("table_full_bank", coeffs, expBank);

    // Three commits during one flush collapse into a single extra swap.
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("multi_first_cnt", W'(commit_cnt), W'(8'd4));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    ovSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
      if (out_valid === 1'b1) ovSeen = 1'b1;
    end
    checkOutput("multi_no_out_valid", W'(ovSeen), W'(1'b0));
    checkOutput("multi_swap_busy", W'(busy), W'(1'b1));
    checkOutput("multi_swap_cnt", W'(commit_cnt), W'(8'd4));
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("multi_second_cnt", W'(commit_cnt), W'(8'd5));
    runFlush(1'b0, n);
    checkOutput("multi_flush_len", W'(n), W'(23));
    checkOutput("multi_final_cnt", W'(commit_cnt), W'(8'd5));

    // Reset during flush restores both banks and discards shadow writes.
    applyStimulus(1'b1, 5'd5, 16'h0AAA, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    checkOutput("mid_tap5", W'(coeffs[80 +: 16]), W'(16'h0AAA));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 5'd0, 16'h0, 1'b0, 1'b1);
    doReset(1'b1, 1'b1);
    checkOutput("midrst_coeffs", coeffs, INIT);
    checkOutput("midrst_cnt", W'(commit_cnt), W'(8'd0));
    checkOutput("midrst_addr_err", W'(addr_err), W'(1'b0));
    checkOutput("midrst_busy", W'(busy), W'(1'b1));

    runFlush(1'b1, n);
    checkOutput("toggle_flush_len", W'(n), W'(46));
    applyStimulus(1'b0, 5'd0, 16'h0, 1'b1, 1'b1);
    runFlush(1'b0, n);
    checkOutput("post_rst_swap_len", W'(n), W'(24));
    checkOutput("post_rst_bank", coeffs, INIT);
    checkOutput("post_rst_cnt", W'(commit_cnt), W'(8'd1));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 21, number of filter taps.
REQ-002 SHALL have parameter CW, default 16, coefficient width (signed).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 23, valid samples needed to refill the filter pipeline (NTAPS + 2 register stages).
REQ-004 SHALL have parameter COEF_INIT, default the 21-tap low-pass set (tap 0 in LSBs), NTAPS*CW bits, power-up coefficients.
REQ-005 clk  in  1  single system clock; all logic is on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cfg_valid  in  1  coefficient write request.
REQ-008 cfg_ready  out  1  write accepted when cfg_valid and cfg_ready are both high.
REQ-009 cfg_addr  in  5  tap index of the write.
REQ-010 cfg_data  in  CW  signed coefficient value.
REQ-011 cfg_commit  in  1  single-cycle pulse requesting shadow-to-active swap.
REQ-012 in_valid  in  1  upstream sample valid, also driven to the filter's valid input.
REQ-013 coeffs  out  NTAPS*CW  active coefficient bank, tap k at bits [k*CW +: CW].
REQ-014 out_valid  out  1  filter output is built entirely from the current active bank.
REQ-015 busy  out  1  high in SWAP or FLUSH.
REQ-016 addr_err  out  1  sticky flag: an accepted write had cfg_addr >= NTAPS.
REQ-017 commit_cnt  out  8  number of completed swaps, wraps 255 -> 0.

Function
REQ-018 SHALL hold two banks, shadow and active, each NTAPS x CW registers.
REQ-019 SHALL implement FSM states RUN, SWAP and FLUSH.
REQ-020 RUN: cfg_ready=1; an accepted write with cfg_addr < NTAPS updates shadow[cfg_addr] at that edge.
REQ-021 An accepted write with cfg_addr >= NTAPS SHALL leave the shadow bank unchanged and set addr_err on the next edge.
REQ-022 In RUN, cfg_commit SHALL move the FSM to SWAP on the next edge.
REQ-023 Simultaneous write and commit in RUN: the write is applied, and the following swap SHALL include it.
REQ-024 SWAP lasts exactly one cycle; it copies shadow to active, increments commit_cnt, clears the flush counter, drops out_valid and enters FLUSH.
REQ-025 coeffs SHALL show the new bank starting the cycle after SWAP (commit-to-coeffs latency 2 cycles).
REQ-026 FLUSH: the counter increments only on cycles with in_valid=1.
REQ-027 FLUSH exits when the counter reaches FLUSH_CYCLES: go to SWAP if a commit is pending, else go to RUN and raise out_valid the same edge.
REQ-028 cfg_ready SHALL be 0 in SWAP and FLUSH; writes presented then are not accepted and must be held by the requester.
REQ-029 A cfg_commit in SWAP or FLUSH SHALL set a single pending flag; multiple commits collapse into one; the flag clears on entry to SWAP.
REQ-030 out_valid is 0 in SWAP and FLUSH and 1 in RUN.
REQ-031 busy = (state != RUN).
REQ-032 The block SHALL never alter in_valid or sample data; it only qualifies output through out_valid.

Reset
REQ-033 On reset, both banks SHALL load COEF_INIT.
REQ-034 On reset: state=FLUSH, flush counter=0, pending=0, addr_err=0, commit_cnt=0, out_valid=0, cfg_ready=0, busy=1.
REQ-035 Reset SHALL take priority over all other inputs in the same cycle.
REQ-036 Reset asserted mid-FLUSH or mid-SWAP SHALL abort the operation and restore COEF_INIT, discarding any uncommitted shadow writes.

Verification
REQ-037 Reset, then in_valid=1 continuously -> out_valid rises after exactly 23 cycles; coeffs equals COEF_INIT throughout; commit_cnt=0.
REQ-038 In RUN, write addr 10 = 0x1000 then pulse commit -> coeffs[10] = 0x1000 two cycles after commit; busy high for 1+23 cycles; commit_cnt=1.
REQ-039 In FLUSH, toggle in_valid 1/0 -> out_valid takes 46 cycles to rise (23 valid samples counted only).
REQ-040 Write and commit in the same cycle (addr 0 = 0x7FFF) -> the swapped bank contains 0x7FFF at tap 0.
REQ-041 Write to addr 25 = 0x1234 -> addr_err=1, shadow unchanged, next commit yields the prior bank; addr_err stays set until reset.
REQ-042 Three commits during FLUSH -> exactly one extra SWAP; commit_cnt +2 total; reset asserted during the second FLUSH -> coeffs return to COEF_INIT and commit_cnt=0.
